// File: rtl/if_id_skid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_skid_pkg : shared constants and state encoding for if_id_skid   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package if_id_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  // The all-zero word is the NOP shown on id_* during bubbles (payloads up to 64 bits).
  localparam logic [63:0] c_ZERO_WORD     = 64'h0;
  localparam logic        c_RESET_ENABLE  = 1'b1;
  localparam logic        c_RESET_DISABLE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/if_id_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_skid : IF->ID valid/ready pipeline register, 2-entry skid,      |
// |              flush and saturating stall counter. Revision 1.0        |
// +----------------------------------------------------------------------+
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_program_counter,
  input  logic [DATA_WIDTH-1:0] if_instruction,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] id_program_counter,
  output logic [DATA_WIDTH-1:0] id_instruction,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  localparam logic [ADDR_WIDTH-1:0] c_PC_NOP    = c_ZERO_WORD[ADDR_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] c_INSTR_NOP = c_ZERO_WORD[DATA_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                  r_state, w_state_nxt;
  logic                    r_id_valid, w_id_valid_nxt;
  logic [ADDR_WIDTH-1:0]   r_id_pc, w_id_pc_nxt;
  logic [DATA_WIDTH-1:0]   r_id_instr, w_id_instr_nxt;
  logic [ADDR_WIDTH-1:0]   r_skid_pc, w_skid_pc_nxt;
  logic [DATA_WIDTH-1:0]   r_skid_instr, w_skid_instr_nxt;
  logic                    r_if_ready;
  logic [CNT_WIDTH-1:0]    r_stall;
  logic                    w_accept;
  logic                    w_transfer;

  assign w_accept   = if_valid & r_if_ready;
  assign w_transfer = r_id_valid & id_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_id_valid_nxt   = r_id_valid;
    w_id_pc_nxt      = r_id_pc;
    w_id_instr_nxt   = r_id_instr;
    w_skid_pc_nxt    = r_skid_pc;
    w_skid_instr_nxt = r_skid_instr;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ST_BUSY;
          w_id_valid_nxt = 1'b1;
          w_id_pc_nxt    = if_program_counter;
          w_id_instr_nxt = if_instruction;
        end
      end
      ST_BUSY: begin
        if (w_accept && w_transfer) begin
          w_id_pc_nxt    = if_program_counter;
          w_id_instr_nxt = if_instruction;
        end else if (w_accept) begin
          w_state_nxt      = ST_FULL;
          w_skid_pc_nxt    = if_program_counter;
          w_skid_instr_nxt = if_instruction;
        end else if (w_transfer) begin
          w_state_nxt    = ST_EMPTY;
          w_id_valid_nxt = 1'b0;
          w_id_pc_nxt    = c_PC_NOP;
          w_id_instr_nxt = c_INSTR_NOP;
        end
      end
      ST_FULL: begin
        // if_ready is low here, so only the drain path is possible.
        if (w_transfer) begin
          w_state_nxt      = ST_BUSY;
          w_id_pc_nxt      = r_skid_pc;
          w_id_instr_nxt   = r_skid_instr;
          w_skid_pc_nxt    = c_PC_NOP;
          w_skid_instr_nxt = c_INSTR_NOP;
        end
      end
      default: begin
        w_state_nxt      = ST_EMPTY;
        w_id_valid_nxt   = 1'b0;
        w_id_pc_nxt      = c_PC_NOP;
        w_id_instr_nxt   = c_INSTR_NOP;
        w_skid_pc_nxt    = c_PC_NOP;
        w_skid_instr_nxt = c_INSTR_NOP;
      end
    endcase

    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_id_valid_nxt   = 1'b0;
      w_id_pc_nxt      = c_PC_NOP;
      w_id_instr_nxt   = c_INSTR_NOP;
      w_skid_pc_nxt    = c_PC_NOP;
      w_skid_instr_nxt = c_INSTR_NOP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset == c_RESET_ENABLE) begin
      r_state      <= ST_EMPTY;
      r_id_valid   <= 1'b0;
      r_id_pc      <= c_PC_NOP;
      r_id_instr   <= c_INSTR_NOP;
      r_skid_pc    <= c_PC_NOP;
      r_skid_instr <= c_INSTR_NOP;
      r_if_ready   <= 1'b1;
      r_stall      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_pc      <= w_id_pc_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_skid_pc    <= w_skid_pc_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      // Registered ready: derived from next state only, never from id_ready directly.
      r_if_ready   <= (w_state_nxt != ST_FULL);
      if (r_id_valid && !id_ready && (r_stall != '1)) begin
        r_stall <= r_stall + c_CNT_ONE;
      end
    end
  end

  assign if_ready           = r_if_ready;
  assign id_valid           = r_id_valid;
  assign id_program_counter = r_id_pc;
  assign id_instruction     = r_id_instr;
  assign stall_cycles       = r_stall;

endmodule
`default_nettype wire

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
Parametrised successor to the fetch/decode pipeline register. Carries {program counter, instruction} from IF to ID using a valid/ready handshake instead of a plain always-load register. Provides a 2-entry skid buffer so the IF side sees a registered ready, plus a flush for branch/exception redirect and a saturating stall counter for performance monitoring. Sits between the fetch unit and the decode unit.

Parameters:
ADDR_WIDTH, 32, width of program counter payload
DATA_WIDTH, 32, width of instruction payload
CNT_WIDTH, 16, width of saturating stall-cycle counter

Ports:
clock  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
flush  input  1  discard all buffered entries (redirect)
if_valid  input  1  IF presents a valid entry
if_ready  output  1  buffer can accept an entry this cycle (registered)
if_program_counter  input  ADDR_WIDTH  IF PC
if_instruction  input  DATA_WIDTH  IF instruction
id_valid  output  1  output entry valid (registered)
id_ready  input  1  ID consumes the entry this cycle
id_program_counter  output  ADDR_WIDTH  PC to ID (registered)
id_instruction  output  DATA_WIDTH  instruction to ID (registered)
stall_cycles  output  CNT_WIDTH  count of cycles with id_valid=1 and id_ready=0

Behaviour:
- Reset: state EMPTY; id_valid=0; id_program_counter and id_instruction = 0; skid cleared to 0; if_ready=1 from the first cycle after reset; stall_cycles=0.
- Definitions: accept = if_valid & if_ready. Transfer = id_valid & id_ready.
- States: EMPTY (no entries), BUSY (output reg holds 1 entry), FULL (output reg plus skid reg hold 2 entries).
- EMPTY: on accept, load the output reg and go to BUSY. Otherwise stay.
- BUSY, accept & transfer: load the output reg from input and stay BUSY. This gives back-to-back throughput of 1 entry per cycle.
- BUSY, accept only: load the skid reg from input and go to FULL.
- BUSY, transfer only: go to EMPTY.
- BUSY, neither: hold.
- FULL: if_ready=0, so no accept is possible. On transfer, move skid to output reg, zero the skid, and go to BUSY. Otherwise hold.
- if_ready is registered. Its next value is 1 unless the next state is FULL. It never depends combinationally on id_ready.
- Bubble rule: whenever id_valid is 0, id_program_counter and id_instruction are 0. The zero word is the NOP.
- Ordering: entries leave in acceptance order. No entry is duplicated or dropped except by flush or reset.
- Latency: an entry accepted in cycle N appears on id_* in cycle N+1 if the buffer was EMPTY, or if it was BUSY with a transfer in cycle N.
- Flush: priority below reset, above everything else.
  - Next state EMPTY; id_valid=0; id payload and skid zeroed; if_ready=1 next cycle.
  - An if_valid entry in the flush cycle is discarded.
  - A transfer in the flush cycle still counts as consumed by ID.
- Reset mid-operation: identical to the reset values above, regardless of state. Flush and reset together behave as reset.
- stall_cycles:
  - Increments by 1 each cycle with id_valid=1 and id_ready=0.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.

Decomposition:
- Shared package/defines: state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10), the zero-word constant, and the ResetEnable/ResetDisable constants.
- No sub-module. The skid slot is one register pair plus the FSM, so a single module of about 150 lines suffices.

Test Plan:
- Reset held 2 cycles, then released -> id_valid=0, id_pc=0, id_instr=0, if_ready=1, stall_cycles=0.
- id_ready=1 constantly; stream PC 0x0,0x4,0x8 with instr 0x24010001,0x24020002,0x24030003 -> each appears 1 cycle later in order with no bubbles; if_ready stays 1.
- Accept PC 0x100 and 0x104 with id_ready=0 -> state FULL, if_ready=0 and id shows 0x100. Hold id_ready=0 for 3 cycles -> stall_cycles=3. Raise id_ready -> 0x100 then 0x104 delivered; if_ready returns 1 the cycle after the first transfer.
- FULL with 0x200/0x204, assert flush with if_valid=1 carrying 0x300 -> next cycle id_valid=0, payload 0, if_ready=1; 0x200, 0x204 and 0x300 are never delivered.
- CNT_WIDTH=4, id_valid=1 with id_ready=0 for 20 cycles -> stall_cycles saturates at 15. Assert flush -> the count stays 15.
- Reset asserted while BUSY with id_ready=0 -> next cycle all outputs at reset values. The next accepted entry 0x400 appears exactly once.
